// File: rtl/piradip_axis_packetizer.sv
// Packetizer: frames an unframed AXI-Stream into pkt_len-beat AXI4-Stream packets
// (tlast/tid/tdest/tkeep/tstrb) through a 2-entry registered skid buffer.
module piradip_axis_packetizer #(
    parameter int WIDTH      = 32,
    parameter int LEN_BITS   = 16,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [LEN_BITS-1:0]   pkt_len,
    input  logic                  flush,
    input  logic [ID_WIDTH-1:0]   id_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [WIDTH-1:0]      s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [WIDTH-1:0]      m_tdata,
    output logic                  m_tlast,
    output logic [WIDTH/8-1:0]    m_tkeep,
    output logic [WIDTH/8-1:0]    m_tstrb,
    output logic [ID_WIDTH-1:0]   m_tid,
    output logic [DEST_WIDTH-1:0] m_tdest,
    output logic [31:0]           pkt_count,
    output logic                  busy
);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                state, state_next;
    logic [LEN_BITS-1:0]   len_r, len_next, idx, idx_next;
    logic [LEN_BITS-1:0]   cur_len, cur_idx;
    logic [ID_WIDTH-1:0]   id_r, id_next, beat_id;
    logic [DEST_WIDTH-1:0] dest_r, dest_next, beat_dest;
    logic                  flag_r, flag_next, beat_last;
    logic                  accept, pop, space_r;
    logic [1:0]            count, count_next;

    logic [WIDTH-1:0]      skid_data;
    logic                  skid_last;
    logic [ID_WIDTH-1:0]   skid_id;
    logic [DEST_WIDTH-1:0] skid_dest;

    // space_r tracks "fewer than two entries held", so the m_tready -> s_tready path is registered
    assign s_tready = space_r & (enable | (state == IN_PKT));
    assign accept   = s_tvalid & s_tready;
    assign m_tvalid = (count != 2'd0);
    assign pop      = m_tvalid & m_tready;
    assign m_tkeep  = '1;
    assign m_tstrb  = '1;
    assign busy     = (state == IN_PKT) | (count != 2'd0);

    always_comb begin
        state_next = state;
        len_next   = len_r;
        idx_next   = idx;
        id_next    = id_r;
        dest_next  = dest_r;
        flag_next  = flag_r | flush;
        cur_len    = len_r;
        cur_idx    = idx;
        beat_id    = id_r;
        beat_dest  = dest_r;
        beat_last  = 1'b0;
        if (state == IDLE) begin
            cur_len   = (pkt_len == '0) ? LEN_BITS'(1) : pkt_len;
            cur_idx   = '0;
            beat_id   = id_in;
            beat_dest = dest_in;
        end
        beat_last = flag_r | flush | (cur_idx == cur_len - LEN_BITS'(1));
        if (accept) begin
            len_next  = cur_len;
            id_next   = beat_id;
            dest_next = beat_dest;
            flag_next = 1'b0;
            if (beat_last) begin
                state_next = IDLE;
                idx_next   = '0;
            end else begin
                state_next = IN_PKT;
                idx_next   = cur_idx + LEN_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            len_r  <= '0;
            idx    <= '0;
            id_r   <= '0;
            dest_r <= '0;
            flag_r <= 1'b0;
        end else begin
            state  <= state_next;
            len_r  <= len_next;
            idx    <= idx_next;
            id_r   <= id_next;
            dest_r <= dest_next;
            flag_r <= flag_next;
        end
    end

    always_comb begin
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Output registers are the head entry; the skid entry only fills when the head is stalled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count     <= '0;
            space_r   <= 1'b0;
            pkt_count <= '0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
            m_tid     <= '0;
            m_tdest   <= '0;
            skid_data <= '0;
            skid_last <= 1'b0;
            skid_id   <= '0;
            skid_dest <= '0;
        end else begin
            count   <= count_next;
            space_r <= (count_next != 2'd2);
            if (pop && m_tlast) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (accept && (count == 2'd0 || pop)) begin
                m_tdata <= s_tdata;
                m_tlast <= beat_last;
                m_tid   <= beat_id;
                m_tdest <= beat_dest;
            end else if (accept) begin
                skid_data <= s_tdata;
                skid_last <= beat_last;
                skid_id   <= beat_id;
                skid_dest <= beat_dest;
            end else if (pop && count == 2'd2) begin
                m_tdata <= skid_data;
                m_tlast <= skid_last;
                m_tid   <= skid_id;
                m_tdest <= skid_dest;
            end
        end
    end

endmodule

// File: doc/piradip_axis_packetizer.md
Name: piradip_axis_packetizer

Overview:
- Framing stage that consumes an unframed sample stream (simple AXI-Stream, tlast ignored) and produces full AXI4-Stream packets.
- Inserts tlast every pkt_len beats and drives tkeep, tstrb, tid and tdest.
- Sits directly upstream of DMA and any other packet-oriented subordinate.
- Output is registered through a 2-entry skid buffer, so both tready paths are registered and full throughput is kept.

Parameters:
- WIDTH, 32, tdata width in bits; must be a multiple of 8.
- LEN_BITS, 16, width of pkt_len and of the internal beat counter.
- ID_WIDTH, 1, m_tid width.
- DEST_WIDTH, 1, m_tdest width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  permit starting new packets.
- pkt_len  in  LEN_BITS  beats per packet; 0 is treated as 1.
- flush  in  1  single-cycle pulse: end the current packet early.
- id_in  in  ID_WIDTH  tid for packets, sampled at packet start.
- dest_in  in  DEST_WIDTH  tdest for packets, sampled at packet start.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input ready.
- s_tdata  in  WIDTH  input data.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  WIDTH  output data.
- m_tlast  out  1  last beat of packet.
- m_tkeep  out  WIDTH/8  always all ones.
- m_tstrb  out  WIDTH/8  always all ones.
- m_tid  out  ID_WIDTH  packet id.
- m_tdest  out  DEST_WIDTH  packet destination.
- pkt_count  out  32  completed packets on the output, wraps at 2^32.
- busy  out  1  high while a packet is open or the skid buffer is non-empty.

Behaviour:
- Reset (async assert, sync release): s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tid=0, m_tdest=0, pkt_count=0, busy=0, beat counter=0, flush flag=0, state=IDLE.
- Input accept: s_tvalid & s_tready.
- Output transfer: m_tvalid & m_tready.
- State machine:
  - IDLE (no open packet): s_tready = enable & skid not full. On accept, latch pkt_len (0 becomes 1) into len_r, and latch id_in and dest_in. The beat is index 0. If len_r==1 or the flush flag is set, the beat is tagged last and the state stays IDLE; otherwise go to IN_PKT.
  - IN_PKT: s_tready = skid not full (enable is ignored mid-packet). Each accepted beat increments the index. A beat is tagged last when index==len_r-1 or the flush flag is set; it then returns to IDLE with the counter cleared.
- pkt_len, id_in and dest_in changes mid-packet have no effect until the next packet start.
- Flush:
  - A flush pulse sets a sticky flag; the next accepted beat is tagged last and the flag clears.
  - Flush in the same cycle as an accept applies to that beat.
  - Flush coinciding with a naturally last beat yields one tlast; the flag clears.
  - Flush in IDLE: the flag persists and the next packet is 1 beat.
- Skid buffer:
  - 2 entries; each holds data, last, id and dest.
  - Latency from input accept to m_tvalid is 1 cycle.
  - Sustains 1 beat/cycle while m_tready=1.
  - Under backpressure the output holds m_tdata, m_tlast, m_tid and m_tdest stable while m_tvalid=1 & m_tready=0.
  - No beat is lost or reordered.
  - s_tready is a register output and deasserts when 2 entries are occupied, or when 1 entry is occupied with an accept and no output transfer in the same cycle.
- m_tvalid must never drop without a transfer.
- pkt_count increments on each output transfer with m_tlast=1.
- m_tkeep and m_tstrb are constant all ones.
- Reset mid-packet: all state is discarded immediately, and the partial packet is neither completed nor counted.

Test Plan:
- pkt_len=4, enable=1, 12 input beats of data 0..11 back-to-back, m_tready=1 -> m_tlast on data 3, 7, 11; first m_tvalid one cycle after the first accept; s_tready stays 1; pkt_count=3.
- pkt_len=5, 20 beats, m_tready random at 50% -> output data sequence 0..19 unchanged; tlast on 4, 9, 14, 19; outputs stable while stalled; pkt_count=4.
- pkt_len=8, flush pulsed in the cycle of the 3rd accept -> packet of 3 beats (tlast on the 3rd); next packet 8 beats; a flush while IDLE makes the following packet 1 beat.
- pkt_len=0 -> every beat has m_tlast=1; pkt_count equals the beat count.
- pkt_len=4, enable dropped after beat 1 -> beats 2 and 3 still accepted, tlast on beat 3, then s_tready=0 until enable=1; changing pkt_len to 2 mid-packet affects only the next packet; id_in/dest_in changes mid-packet appear only from the next packet.
- resetn asserted mid-packet with skid full -> outputs immediately at reset values; after release, pkt_len=4 produces a fresh 4-beat packet and pkt_count=1.
